// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - fetch-side instruction queue between aligner and decode (optional INSTR_BUFFER_PERF_EN stall counter)
module instr_buffer #(
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_instr,
  input  logic [3:0]   in_instr_valid,
  input  logic [63:0]  in_pc,
  input  logic         out_ready,
  output logic         out0_valid,
  output logic [31:0]  out0_instr,
  output logic [63:0]  out0_pc,
  output logic         out1_valid,
  output logic [31:0]  out1_instr,
  output logic [63:0]  out1_pc,
  output logic [31:0]  stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_TWO   = cnt_t'(2);
  localparam cnt_t CNT_FOUR  = cnt_t'(4);

  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc_mem    [DEPTH];

  ptr_t head;
  ptr_t tail;
  ptr_t head_p1;
  cnt_t count;
  cnt_t free_cnt;
  cnt_t n_enq;
  cnt_t n_pop;
  cnt_t n_acc;
  logic enq_fire;

  // Readiness, output slots and per-cycle enqueue/dequeue amounts from registered state
  always_comb begin
    n_enq = cnt_t'(in_instr_valid[0]) + cnt_t'(in_instr_valid[1])
          + cnt_t'(in_instr_valid[2]) + cnt_t'(in_instr_valid[3]);
    free_cnt   = CNT_DEPTH - count;
    in_ready   = (free_cnt >= CNT_FOUR);
    enq_fire   = in_valid && in_ready && !flush;
    n_acc      = enq_fire ? n_enq : '0;
    head_p1    = head + ptr_t'(1);
    out0_valid = !flush && (count >= CNT_ONE);
    out1_valid = !flush && (count >= CNT_TWO);
    out0_instr = '0;
    out0_pc    = '0;
    out1_instr = '0;
    out1_pc    = '0;
    if (out0_valid) begin
      out0_instr = instr_mem[head];
      out0_pc    = pc_mem[head];
    end
    if (out1_valid) begin
      out1_instr = instr_mem[head_p1];
      out1_pc    = pc_mem[head_p1];
    end
    n_pop = '0;
    if (out_ready) begin
      if (out1_valid) begin
        n_pop = CNT_TWO;
      end else if (out0_valid) begin
        n_pop = CNT_ONE;
      end
    end
  end

  // Write the accepted lanes at consecutive slots after tail, each with its own PC
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_t'(k) < n_enq) begin
          instr_mem[tail + ptr_t'(k)] <= in_instr[32*k +: 32];
          pc_mem[tail + ptr_t'(k)]    <= in_pc + 64'(4 * k);
        end
      end
    end
  end

  // Pointer and occupancy update; flush and reset both empty the queue
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_pop[AW-1:0];
      tail  <= tail + n_acc[AW-1:0];
      count <= count + n_acc - n_pop;
    end
  end

`ifdef INSTR_BUFFER_PERF_EN
  // Saturating count of cycles where fetch offered a group but had no room
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - self-checking bench for instr_buffer against a queue reference model
module tb_instr_buffer;
  localparam int DEPTH = 16;
  localparam int TIMEOUT_NS = 200000;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_instr;
  logic [3:0]   in_instr_valid;
  logic [63:0]  in_pc;
  logic         out_ready;
  logic         out0_valid;
  logic [31:0]  out0_instr;
  logic [63:0]  out0_pc;
  logic         out1_valid;
  logic [31:0]  out1_instr;
  logic [63:0]  out1_pc;
  logic [31:0]  stall_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_stall;
  int          cur_n;
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_instr_valid(in_instr_valid), .in_pc(in_pc), .out_ready(out_ready),
    .out0_valid(out0_valid), .out0_instr(out0_instr), .out0_pc(out0_pc),
    .out1_valid(out1_valid), .out1_instr(out1_instr), .out1_pc(out1_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input int n);
    case (n)
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv, input int n,
                       input logic [63:0] pc, input logic ordy);
    reset          = rst;
    flush          = fl;
    in_valid       = iv;
    cur_n          = n;
    in_instr_valid = mask_of(n);
    in_pc          = pc;
    in_instr       = {$urandom, $urandom, $urandom, $urandom};
    out_ready      = ordy;
  endtask

  task automatic cycle();
    int   sz;
    int   npop;
    logic rdy;
    logic e0v;
    logic e1v;
    ent_t e0;
    ent_t e1;
    ent_t ne;
    @(negedge clock);
    sz  = q.size();
    rdy = (DEPTH - sz) >= 4;
    if (!reset) begin
      e0v = !flush && (sz >= 1);
      e1v = !flush && (sz >= 2);
      e0  = e0v ? q[0] : '0;
      e1  = e1v ? q[1] : '0;
      chk("in_ready", in_ready, rdy);
      chk("out0_valid", out0_valid, e0v);
      chk("out1_valid", out1_valid, e1v);
      chk("out0_instr", out0_instr, e0.instr);
      chk("out0_pc", out0_pc, e0.pc);
      chk("out1_instr", out1_instr, e1.instr);
      chk("out1_pc", out1_pc, e1.pc);
      chk("stall_cnt", stall_cnt, exp_stall);
    end
    if (reset) begin
      q.delete();
      exp_stall = '0;
    end else if (flush) begin
      q.delete();
    end else begin
`ifdef INSTR_BUFFER_PERF_EN
      if (in_valid && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
      if (out_ready) begin
        npop = (sz >= 2) ? 2 : sz;
        for (int i = 0; i < npop; i++) void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        for (int k = 0; k < cur_n; k++) begin
          ne.instr = in_instr[32*k +: 32];
          ne.pc    = in_pc + 64'(4 * k);
          q.push_back(ne);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      bad++;
      $error("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
      $finish;
    end
  end

  initial begin
    logic [31:0] lane0;
    logic [31:0] lane1;
    logic [63:0] pc;
    exp_stall = '0;
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 1'b0);
    cycle();
    cycle();

    // reset state
    drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
    cycle();
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_v0", out0_valid, 1'b0);

    // full group at 0x8000_0000, decode stalled
    drive(1'b0, 1'b0, 1'b1, 4, 64'h8000_0000, 1'b0);
    lane0 = in_instr[31:0];
    lane1 = in_instr[63:32];
    cycle();
    drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
    chk("g1_pc0", out0_pc, 64'h8000_0000);
    chk("g1_pc1", out1_pc, 64'h8000_0004);
    chk("g1_i0", out0_instr, lane0);
    chk("g1_i1", out1_instr, lane1);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 0, 64'h0, 1'b0);
    cycle();

    // partial groups drained by decode
    drive(1'b0, 1'b0, 1'b1, 2, 64'h100, 1'b1);
    cycle();
    chk("p_pc0", out0_pc, 64'h100);
    chk("p_pc1", out1_pc, 64'h104);
    drive(1'b0, 1'b0, 1'b1, 1, 64'h200, 1'b1);
    cycle();
    chk("p2_pc0", out0_pc, 64'h200);
    chk("p2_v1", out1_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b1);
    cycle();
    chk("p_empty", out0_valid, 1'b0);

    // fill to DEPTH with held in_valid, then drain
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4, 64'h4000 + 64'(16 * i), 1'b0);
      cycle();
    end
    chk("full_ready", in_ready, 1'b0);
    chk("full_pc0", out0_pc, 64'h4000);
`ifdef INSTR_BUFFER_PERF_EN
    chk("full_stall", stall_cnt, 32'd2);
`endif
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b1);
      cycle();
    end
    chk("drained", out0_valid, 1'b0);

    // count = DEPTH-3: not ready even while popping two
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4, 64'h5000 + 64'(16 * i), 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b1, 1, 64'h5030, 1'b0);
    cycle();
    chk("c13_ready", in_ready, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4, 64'h6000, 1'b1);
    cycle();
    chk("c11_ready", in_ready, 1'b1);
    chk("c11_pc0", out0_pc, 64'h5008);
    drive(1'b0, 1'b1, 1'b0, 0, 64'h0, 1'b0);
    cycle();

    // steady stream through pointer wrap
    pc = 64'h1000;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4, pc, 1'b1);
      if (in_ready) pc = pc + 64'd16;
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b1);
      cycle();
    end

    // flush at count 7 with enqueue and dequeue offered
    drive(1'b0, 1'b0, 1'b1, 4, 64'h7000, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 3, 64'h7010, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 4, 64'h7100, 1'b1);
    cycle();
    chk("fl_v0", out0_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);

    // 64-bit PC wrap across lanes
    drive(1'b0, 1'b0, 1'b1, 4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b1);
    chk("wrap_pc0", out0_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_pc1", out1_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    chk("wrap_pc2", out0_pc, 64'h0);
    chk("wrap_pc3", out1_pc, 64'h4);

    // mid-operation reset
    drive(1'b1, 1'b0, 1'b1, 4, 64'h9000, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4)),
            {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
      cycle();
    end

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Fetch-side instruction queue that consumes the 128-bit aligned fetch group and its 4-bit lane-valid mask from the instruction aligner. It enqueues 0–4 instructions per cycle, tags each with its PC, and presents up to two in-order instructions per cycle to decode. It sits between the instruction aligner and the decoder and absorbs fetch/decode rate mismatch, including stalls.

## Interface
- DEPTH, 16, queue entries (32-bit instr + 64-bit PC each); power of two, ≥ 8
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  redirect; discards all queued instructions
- in_valid  in  1  aligned fetch group present
- in_ready  out  1  space for a full group (≥ 4 free entries)
- in_instr  in  128  aligned instructions; lane k = bits [32k+31:32k]
- in_instr_valid  in  4  lane-valid mask, always LSB-contiguous (1111/0111/0011/0001/0000)
- in_pc  in  64  PC of lane 0
- out_ready  in  1  decode accepts this cycle's output slots
- out0_valid / out1_valid  out  1 each  head / head+1 valid
- out0_instr / out1_instr  out  32 each  instruction
- out0_pc / out1_pc  out  64 each  instruction PC
- stall_cnt  out  32  fetch back-pressure cycle count (see Configuration)

## Operation
- Storage: circular array of DEPTH entries; head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits).
- Enqueue fires when in_valid && in_ready && !flush. n = popcount(in_instr_valid), 0..4. Lane k (k<n) written to entry (tail+k) mod DEPTH with PC = in_pc + 4·k (64-bit, wraps). tail += n. n = 0 is a legal no-op.
- in_ready = (DEPTH − count) ≥ 4, from the registered count only; same-cycle dequeue is not credited.
- Outputs read combinationally from registered storage: out0 = entry[head] when count ≥ 1; out1 = entry[head+1 mod DEPTH] when count ≥ 2. out1_valid implies out0_valid. Invalid slots drive instr/pc = 0.
- Dequeue: when out_ready && !flush, pop = number of valid out slots (0, 1 or 2); head += pop.
- count_next = count + n_enq − pop; simultaneous enqueue and dequeue are both honoured.
- flush has priority over everything: head, tail and count are cleared to 0 next cycle; the flush cycle's enqueue and dequeue are ignored; out0_valid/out1_valid are forced to 0 during the flush cycle.
- Order: instructions leave in exact enqueue order, across groups and across pointer wrap.

## Timing
- Reset: head = tail = count = 0; in_ready = 1; out*_valid = 0; out*_instr = 0; out*_pc = 0; stall_cnt = 0. Storage contents need no reset.
- Enqueue-to-visible latency: 1 cycle. A group accepted in cycle t appears at out0/out1 in cycle t+1 if the queue was empty.
- Dequeue takes effect at the clock edge; the next pair is presented in the following cycle.
- Full boundary: at count = DEPTH−3, in_ready = 0 even if decode pops 2 that cycle.
- Empty boundary: at count = 0 both valids are 0; out_ready has no effect.
- Reset asserted mid-operation behaves as flush plus clearing of stall_cnt.

## Configuration
- INSTR_BUFFER_PERF_EN defined: stall_cnt increments by 1 every cycle with in_valid && !in_ready && !flush, saturates at 0xFFFFFFFF, and is cleared only by reset.
- Not defined: stall_cnt is tied to 0 and no counter logic is built. The port is always present.

## Test plan
- After reset, one group with mask 1111 and in_pc = 0x8000_0000, out_ready = 0 → next cycle count = 4, out0 = lane0 @0x8000_0000, out1 = lane1 @0x8000_0004.
- Mask 0011 @0x100, then 0001 @0x200, with out_ready = 1 → decode sees (0x100, 0x104) then (0x200, none); count returns to 0.
- Fill with out_ready = 0 using 1111 groups until in_ready = 0 at count = 16 (DEPTH = 16); a held in_valid is not accepted; with the macro on, stall_cnt advances once per stalled cycle.
- Steady enqueue of 1111 with 2/cycle drain across more than 2·DEPTH instructions → PCs strictly sequential through pointer wrap; no loss or duplication.
- flush with count = 7, in_valid = 1 and out_ready = 1 in the same cycle → both valids are 0 that cycle, count = 0 next cycle, and the input group is dropped.
- in_pc = 0xFFFF_FFFF_FFFF_FFF8 with mask 1111 → lane PCs are …FFF8, …FFFC, 0x0, 0x4.
